// File: rtl/spi_pkg.sv
// Shared widths, divider setting and master state encoding for the SPI loopback pair.
package spi_pkg;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned CLK_DIV = 10;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned BIT_W   = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, SEND} mst_state_e;
endpackage

// File: rtl/spi_if.sv
// Request/response bundle of the SPI loopback: word in with request, word out with done.
interface spi_if;
  logic                        newd;
  logic [spi_pkg::DATA_W-1:0]  din;
  logic [spi_pkg::DATA_W-1:0]  dout;
  logic                        done;

  modport master (output newd, output din, input dout, input done);
  modport slave  (input newd, input din, output dout, output done);
endinterface

// File: rtl/spi_master.sv
// SPI master: sclk divider with registered edge strobes, and an LSB-first serialiser
// that steps on every sclk rise.
module spi_master
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              newd_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              cs_o,
  output logic              mosi_o,
  output logic              fall_stb_o
);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              sclk, sclk_d;
  logic              rise_stb_q, rise_stb_d;
  logic              fall_stb_q, fall_stb_d;
  mst_state_e        state_q, state_d;
  logic [BIT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;

  // Strobes are high in the first clk cycle of each new sclk level.
  always_comb begin
    div_d      = div_q + DIV_W'(1);
    sclk_d     = sclk;
    rise_stb_d = 1'b0;
    fall_stb_d = 1'b0;
    if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d      = '0;
      sclk_d     = ~sclk;
      rise_stb_d = ~sclk;
      fall_stb_d = sclk;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    if (rise_stb_q) begin
      unique case (state_q)
        IDLE: begin
          cs_d = 1'b1;
          if (newd_i) begin
            shreg_d = din_i;
            cs_d    = 1'b0;
            mosi_d  = din_i[0];
            cnt_d   = BIT_W'(1);
            state_d = SEND;
          end
        end
        SEND: begin
          if (cnt_q < BIT_W'(DATA_W)) begin
            mosi_d = shreg_q[cnt_q];
            cnt_d  = cnt_q + BIT_W'(1);
          end else begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      sclk       <= 1'b0;
      rise_stb_q <= 1'b0;
      fall_stb_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      sclk       <= sclk_d;
      rise_stb_q <= rise_stb_d;
      fall_stb_q <= fall_stb_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
    end
  end

  assign cs_o       = cs_q;
  assign mosi_o     = mosi_q;
  assign fall_stb_o = fall_stb_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: samples mosi on each sclk fall while cs is low and publishes the
// assembled word with a one-sclk-period done pulse.
module spi_slave
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fall_stb_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              done_o
);

  logic [BIT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    dout_d = dout_q;
    done_d = done_q;
    if (fall_stb_i) begin
      done_d = 1'b0;
      if (cs_i) begin
        cnt_d = '0;
      end else begin
        data_d[cnt_q] = mosi_i;
        if (cnt_q == BIT_W'(DATA_W - 1)) begin
          dout_d = data_d;
          done_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + BIT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      data_q <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      dout_q <= dout_d;
      done_q <= done_d;
    end
  end

  assign dout_o = dout_q;
  assign done_o = done_q;

endmodule

// File: rtl/spi_top.sv
// Self-contained SPI loopback: master serialises a word, slave reassembles it;
// the SPI wires never leave this block.
module spi_top
  import spi_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  spi_if.slave  bus
);

  logic cs;
  logic mosi;
  logic fall_stb;

  spi_master spi_m (
    .clk        (clk),
    .rst        (rst),
    .newd_i     (bus.newd),
    .din_i      (bus.din),
    .cs_o       (cs),
    .mosi_o     (mosi),
    .fall_stb_o (fall_stb)
  );

  spi_slave spi_s (
    .clk        (clk),
    .rst        (rst),
    .fall_stb_i (fall_stb),
    .cs_i       (cs),
    .mosi_i     (mosi),
    .dout_o     (bus.dout),
    .done_o     (bus.done)
  );

endmodule

// File: tb/tb_spi_top.sv
// Scoreboard bench for the SPI loopback: stimulus pushes accepted words, a monitor
// pops and checks them at every done rise along with bit order, latency and widths.
module tb_spi_top;

  logic clk = 1'b0;
  logic rst;

  spi_if bus ();

  spi_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int push_cnt = 0;
  int done_cnt = 0;
  logic [11:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_cs(input logic val);
    int n;
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      if (dut.spi_m.cs_q === val) return;
      n++;
    end
    tests++;
    fails++;
    $display("FAIL wait_cs: cs never reached %0b (still %0b)", val, dut.spi_m.cs_q);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d words still pending, expected 0", exp_q.size());
    end
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] w);
    wait_cs(1'b1);
    bus.newd = 1'b1;
    bus.din  = w;
    wait_cs(1'b0);
    exp_q.push_back(w);
    push_cnt++;
    bus.newd = 1'b0;
  endtask

  // Monitor: edge tracking on sampled values, checks fire at done transitions.
  bit          p_sclk, p_cs, p_done, acc_v, gap_v;
  bit          m_sclk, m_cs, m_done, m_mosi;
  int          mcyc, acc_cyc, rise_cyc, dwidth, bidx;
  logic [11:0] mword, e;

  initial begin
    mcyc = 0; p_sclk = 0; p_cs = 1; p_done = 0; acc_v = 0; gap_v = 0;
    dwidth = 0; bidx = 0; mword = '0; acc_cyc = 0; rise_cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      mcyc++;
      if (rst) begin
        p_sclk = 0; p_cs = 1; p_done = 0; acc_v = 0; gap_v = 0; dwidth = 0;
        continue;
      end
      m_sclk = dut.spi_m.sclk;
      m_cs   = dut.spi_m.cs_q;
      m_mosi = dut.spi_m.mosi_q;
      m_done = bus.done;
      if (p_cs && !m_cs) begin
        if (gap_v) chk("cs_gap_ge_20", 32'(mcyc - rise_cyc >= 20), 32'd1);
        acc_cyc = mcyc; acc_v = 1; bidx = 0; mword = '0;
      end
      if (!p_cs && m_cs) begin
        rise_cyc = mcyc; gap_v = 1;
      end
      if (p_sclk && !m_sclk && !m_cs) begin
        if (bidx < 12) mword[bidx] = m_mosi;
        bidx++;
      end
      if (m_done && !p_done) begin
        done_cnt++;
        dwidth = 0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done with dout=0x%0h, expected no done", bus.dout);
        end else begin
          e = exp_q.pop_front();
          chk("dout", 32'(bus.dout), 32'(e));
          chk("mosi_lsb_first", 32'(mword), 32'(e));
          chk("mosi_bit_count", 32'(bidx), 32'd12);
          if (acc_v) chk("done_latency", 32'(mcyc - acc_cyc), 32'd230);
        end
      end
      if (m_done) dwidth++;
      if (!m_done && p_done) chk("done_width", 32'(dwidth), 32'd20);
      p_sclk = m_sclk; p_cs = m_cs; p_done = m_done;
    end
  end

  logic [11:0] words [4] = '{12'h000, 12'hFFF, 12'h001, 12'h800};
  int          dc;

  initial begin
    rst      = 1'b1;
    bus.newd = 1'b0;
    bus.din  = '0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("rst_sclk", 32'(dut.spi_m.sclk), 32'd0);
      chk("rst_cs", 32'(dut.spi_m.cs_q), 32'd1);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
    end
    rst = 1'b0;

    send(12'hA5C);
    drain();

    foreach (words[i]) begin
      send(words[i]);
      drain();
    end

    // Back-to-back transfers with newd held high.
    wait_cs(1'b1);
    bus.newd = 1'b1;
    bus.din  = 12'h3C3;
    wait_cs(1'b0);
    exp_q.push_back(12'h3C3); push_cnt++;
    bus.din = 12'h15A;
    wait_cs(1'b1);
    wait_cs(1'b0);
    exp_q.push_back(12'h15A); push_cnt++;
    bus.newd = 1'b0;
    drain();

    // din changes mid-transfer must not leak into the word.
    send(12'h123);
    repeat (40) @(posedge clk);
    #1;
    bus.din = 12'hFFF;
    drain();

    // Reset after six bits aborts the transfer.
    wait_cs(1'b1);
    bus.newd = 1'b1;
    bus.din  = 12'h7E1;
    wait_cs(1'b0);
    bus.newd = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    dc  = done_cnt;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_dout", 32'(bus.dout), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
    chk("abort_dout_hold", 32'(bus.dout), 32'd0);

    send(12'h456);
    drain();

    for (int i = 0; i < 10; i++) begin
      send(12'($urandom));
      drain();
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("one_done_per_word", 32'(done_cnt), 32'(push_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
